// File: rtl/sevseg_pkg.sv
// Shared types and encoders for the multiplexed seven-segment scan driver.
// Segment bytes here are active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the output register.
package sevseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF  = 8'h00;
    localparam seg_t SEG_DASH = 8'h40;

    function automatic seg_t hex_encode(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/sevseg_bin2bcd.sv
// Sequential double-dabble converter: one shift per clock, BIN_W clocks per conversion.
// Only instantiated when SEVSEG_BCD_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | add-3 and shift, one input bit per cycle
// DONE  | result valid for one cycle; a new start may be accepted here
module sevseg_bin2bcd
    import sevseg_pkg::*;
#(
    parameter int BIN_W      = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int REM_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} cvt_state_t;

    cvt_state_t       state, state_nxt;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [REM_W-1:0] shifts_left;
    logic             ovf;
    logic             load;

    assign ready    = (state != SHIFT);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign load     = start && ready;
    assign bcd_out  = bcd_sr;
    assign overflow = ovf;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (BIN_W == 1) ? DONE : SHIFT;
            SHIFT:   if (shifts_left == REM_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = start ? ((BIN_W == 1) ? DONE : SHIFT) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The first shift happens on load: add-3 on an all-zero BCD register is a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr      <= '0;
            bcd_sr      <= '0;
            shifts_left <= '0;
            ovf         <= 1'b0;
        end else if (load) begin
            bcd_sr      <= BCD_W'(bin_in[BIN_W-1]);
            bin_sr      <= bin_in << 1;
            shifts_left <= REM_W'(BIN_W - 1);
            ovf         <= (64'(bin_in) >= LIMIT);
        end else if (state == SHIFT) begin
            bcd_sr      <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
            bin_sr      <= bin_sr << 1;
            shifts_left <= shifts_left - 1'b1;
        end
    end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed seven-segment scan driver with leading-zero and anti-ghost blanking.
// Define SEVSEG_BCD_EN to treat number_in as unsigned binary shown in decimal.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 16384,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 1,
    parameter int BIN_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] number_in,
    input  logic                    number_valid,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hold,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic [7:0]              sevenseg_out,
    output logic [NUM_DIGITS-1:0]   sevseg_active
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TC  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             ACT_LO    = (ACTIVE_LOW != 0);

    if (BIN_W < 1 || BIN_W > DW) begin : g_bad_bin_w
        $error("sevseg_scan_driver: BIN_W must be in 1..4*NUM_DIGITS");
    end

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [DW-1:0]         disp_reg;
    logic [NUM_DIGITS-1:0] dp_reg;
    logic                  disp_ovf;
    logic                  strobe;

    assign strobe = number_valid && !hold;

`ifdef SEVSEG_BCD_EN
    logic                  cvt_start, cvt_ready, cvt_done, cvt_busy, cvt_ovf;
    logic [BIN_W-1:0]      cvt_bin;
    logic [DW-1:0]         cvt_bcd;
    logic [NUM_DIGITS-1:0] cvt_dp_in, cvt_dp;
    logic                  pend_valid;
    logic [BIN_W-1:0]      pend_bin;
    logic [NUM_DIGITS-1:0] pend_dp;

    sevseg_bin2bcd #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (cvt_start),
        .bin_in   (cvt_bin),
        .busy     (cvt_busy),
        .ready    (cvt_ready),
        .done     (cvt_done),
        .bcd_out  (cvt_bcd),
        .overflow (cvt_ovf)
    );

    // A fresh strobe supersedes anything pending, so it goes straight in when the converter is free.
    always_comb begin
        cvt_start = 1'b0;
        cvt_bin   = number_in[BIN_W-1:0];
        cvt_dp_in = dp_in;
        if (cvt_ready) begin
            if (strobe) begin
                cvt_start = 1'b1;
            end else if (pend_valid) begin
                cvt_start = 1'b1;
                cvt_bin   = pend_bin;
                cvt_dp_in = pend_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_bin   <= '0;
            pend_dp    <= '0;
            cvt_dp     <= '0;
            disp_reg   <= '0;
            dp_reg     <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            if (cvt_start) cvt_dp <= cvt_dp_in;
            if (strobe && !cvt_ready) begin
                pend_valid <= 1'b1;
                pend_bin   <= number_in[BIN_W-1:0];
                pend_dp    <= dp_in;
            end else if (cvt_start) begin
                pend_valid <= 1'b0;
            end
            if (cvt_done) begin
                disp_reg <= cvt_bcd;
                dp_reg   <= cvt_dp;
                disp_ovf <= cvt_ovf;
            end
        end
    end

    assign busy = cvt_busy;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= '0;
            dp_reg   <= '0;
        end else if (strobe) begin
            disp_reg <= number_in;
            dp_reg   <= dp_in;
        end
    end

    assign disp_ovf = 1'b0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    // lz_mask[i]: digit i and everything above it is zero; digit 0 never qualifies.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (disp_reg[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [NUM_DIGITS-1:0] an_nxt;
    seg_t                  seg_nxt;

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_sel  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = disp_reg[4*i +: 4];
                cur_dp    = dp_reg[i];
                cur_lz    = lz_mask[i];
                an_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = '0;
        if (slot_cnt >= BLANK_TC) begin
            an_nxt = an_sel;
            if (disp_ovf)                seg_nxt = SEG_DASH;
            else if (blank_lz && cur_lz) seg_nxt = SEG_OFF;
            else                         seg_nxt = hex_encode(cur_nib);
            seg_nxt[7] = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sevenseg_out  <= {8{ACT_LO}};
            sevseg_active <= {NUM_DIGITS{ACT_LO}};
        end else begin
            sevenseg_out  <= seg_nxt ^ {8{ACT_LO}};
            sevseg_active <= an_nxt ^ {NUM_DIGITS{ACT_LO}};
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Randomised scoreboard bench for sevseg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
module tb_sevseg_scan_driver;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int BLK = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] number_in = '0;
    logic        number_valid = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        hold = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [7:0]  sevenseg_out;
    logic [3:0]  sevseg_active;

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1), .BIN_W(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .number_in     (number_in),
        .number_valid  (number_valid),
        .dp_in         (dp_in),
        .hold          (hold),
        .blank_lz      (blank_lz),
        .busy          (busy),
        .sevenseg_out  (sevenseg_out),
        .sevseg_active (sevseg_active)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int cvt_free = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Display-state change taking effect on the output sampled after edge number eff.
    typedef struct {
        int          eff;
        bit          is_blz;
        logic [15:0] val;
        logic [3:0]  dp;
        bit          ovf;
        bit          blz;
    } upd_t;

    upd_t sbq[$];

    logic [15:0] cur_val = '0;
    logic [3:0]  cur_dp = '0;
    bit          cur_ovf = 1'b0;
    bit          cur_blz = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d t=%0t: got %0h expected %0h", name, edge_n, $time, got, exp);
        end
    endtask

    // Output after edge n shows the scan position reached after n-1 edges.
    function automatic void model(input int n, output logic [7:0] es, output logic [3:0] ea);
        int         p, d;
        logic [3:0] nib;
        logic [6:0] s;
        es = 8'hFF;
        ea = 4'hF;
        if (n < 1) return;
        p = (n - 1) % R;
        d = ((n - 1) / R) % N;
        if (p < BLK) return;
        ea  = ~(4'b0001 << d);
        nib = 4'(cur_val >> (4 * d));
        if (cur_ovf)                                        s = 7'h40;
        else if (cur_blz && d > 0 && (cur_val >> (4*d)) == 0) s = 7'h00;
        else                                                s = hex_tab[nib];
        es = ~{cur_dp[d], s};
    endfunction

    always @(negedge clk) begin : monitor
        logic [7:0] es;
        logic [3:0] ea;
        int         i;
        if (!rst_n) begin
            sbq.delete();
            cur_val = '0;
            cur_dp  = '0;
            cur_ovf = 1'b0;
            cur_blz = blank_lz;
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            i = 0;
            while (i < sbq.size()) begin
                if (sbq[i].eff <= edge_n) begin
                    if (sbq[i].is_blz) begin
                        cur_blz = sbq[i].blz;
                    end else begin
                        cur_val = sbq[i].val;
                        cur_dp  = sbq[i].dp;
                        cur_ovf = sbq[i].ovf;
                    end
                    sbq.delete(i);
                end else begin
                    i++;
                end
            end
            model(edge_n, es, ea);
        end
        chk("segments", {24'h0, sevenseg_out}, {24'h0, es});
        chk("anodes", {28'h0, sevseg_active}, {28'h0, ea});
`ifndef SEVSEG_BCD_EN
        chk("busy_tied", {31'h0, busy}, 32'h0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic set_blz(input bit b);
        upd_t u;
        blank_lz = b;
        u.eff = edge_n + 1;
        u.is_blz = 1'b1;
        u.val = '0;
        u.dp = '0;
        u.ovf = 1'b0;
        u.blz = b;
        sbq.push_back(u);
    endtask

    task automatic strobe(input logic [15:0] v, input logic [3:0] d, input bit h);
        upd_t u;
        int   m;
        int   st;
        number_in = v;
        dp_in = d;
        hold = h;
        number_valid = 1'b1;
        m = edge_n + 1;
        if (!h) begin
            u.is_blz = 1'b0;
            u.blz = 1'b0;
            u.dp = d;
`ifdef SEVSEG_BCD_EN
            st = (m >= cvt_free) ? m : cvt_free;
            cvt_free = st + 16;
            u.eff = cvt_free + 1;
            u.ovf = (int'(v) >= 10000);
            u.val = to_bcd(int'(v));
`else
            st = m;
            u.eff = st + 1;
            u.ovf = 1'b0;
            u.val = v;
`endif
            sbq.push_back(u);
        end
        tick();
        number_valid = 1'b0;
        hold = 1'b0;
        number_in = 16'($urandom);
        dp_in = 4'($urandom);
    endtask

    task automatic wait_free();
        int g;
        g = 0;
        while (edge_n + 1 < cvt_free && g < 100) begin
            tick();
            g++;
        end
    endtask

    initial begin : stim
        int          g;
        int          act;
        logic [15:0] v;
        logic [15:0] mask;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        strobe(16'h1A2F, 4'b0000, 1'b0);
        repeat (40) tick();

        set_blz(1'b1);
        strobe(16'h0005, 4'b0000, 1'b0);
        repeat (20) tick();
        strobe(16'h0005, 4'b1010, 1'b0);
        repeat (20) tick();
        set_blz(1'b0);
        repeat (20) tick();

        strobe(16'h1234, 4'b0000, 1'b0);
        repeat (20) tick();
        strobe(16'hFFFF, 4'b1111, 1'b1);
        repeat (20) tick();

`ifdef SEVSEG_BCD_EN
        wait_free();
        repeat (20) tick();
        strobe(16'd1234, 4'b0001, 1'b0);
        g = 0;
        while (busy && g < 100) begin
            g++;
            tick();
        end
        chk("busy_cycles", 32'(g), 32'd16);
        repeat (30) tick();
        strobe(16'd12345, 4'b0000, 1'b0);
        wait_free();
        repeat (30) tick();
        strobe(16'd4321, 4'b0000, 1'b0);
        repeat (5) tick();
        chk("busy_mid", {31'h0, busy}, 32'h1);
        strobe(16'd42, 4'b0100, 1'b0);
        wait_free();
        repeat (30) tick();
`endif

        for (int it = 0; it < 150; it++) begin
            act = $urandom_range(0, 9);
            if (act < 6) begin
                case ($urandom_range(0, 3))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h00FF;
                    2: mask = 16'h000F;
                    default: mask = 16'h0F00;
                endcase
`ifdef SEVSEG_BCD_EN
                wait_free();
                v = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999) & int'(mask));
`else
                v = 16'($urandom) & mask;
`endif
                strobe(v, 4'($urandom), ($urandom_range(0, 3) == 0));
            end else if (act < 8) begin
                set_blz(1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 8)) tick();
        end

        wait_free();
        repeat (20) tick();
        g = 0;
        while (!((((edge_n - 1) % 16) / 4 == 2) && ((edge_n - 1) % 4 == 2)) && g < 40) begin
            tick();
            g++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_seg", {24'h0, sevenseg_out}, 32'hFF);
        chk("async_reset_an", {28'h0, sevseg_active}, 32'hF);
        cvt_free = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) tick();
        strobe(16'hBEEF, 4'b1000, 1'b0);
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver; successor to the fixed 4-digit debug display.
- Latches a debug value (e.g. CPU PC, PPU scanline) and time-multiplexes it across NUM_DIGITS common-anode digits.
- Adds per-digit decimal points, leading-zero blanking, anti-ghost blanking, hold/freeze and selectable output polarity.
- Instantiated by the top level on clkMaster, next to the NES core.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 16384, clk cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off.
- ACTIVE_LOW, 1, 1 = segments and anodes driven low-active; 0 = high-active.
- BIN_W, 16, binary input width; used only with SEVSEG_BCD_EN. Requires BIN_W <= 4*NUM_DIGITS.

Ports:
- clk, in, 1, master clock.
- rst_n, in, 1, asynchronous active-low reset.
- number_in, in, 4*NUM_DIGITS, value to display; hex nibbles, digit 0 = bits [3:0].
- number_valid, in, 1, sample strobe for number_in.
- dp_in, in, NUM_DIGITS, decimal-point enables; sampled with number_in.
- hold, in, 1, freeze: number_valid is ignored while high.
- blank_lz, in, 1, leading-zero blanking enable; sampled live.
- busy, out, 1, conversion in progress (BCD build only; else constant 0).
- sevenseg_out, out, 8, {dp,g,f,e,d,c,b,a}; registered.
- sevseg_active, out, NUM_DIGITS, one-hot anode enables; registered.

Behaviour:
- Reset (async assert, sync release):
  - disp_reg=0, dp_reg=0, slot counter=0, digit index=0.
  - All outputs inactive: ACTIVE_LOW=1 gives all ones; ACTIVE_LOW=0 gives all zeros. busy=0.
- Capture (hex build):
  - On a clk edge with number_valid=1 and hold=0: disp_reg<=number_in and dp_reg<=dp_in.
  - The new value affects outputs from the following cycle onward (1-cycle latency to the output register).
  - Values never tear mid-slot-boundary; the display always shows a coherent disp_reg.
- Scan:
  - Slot counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - Counter < BLANK_CYCLES: all anodes inactive and segments inactive.
  - Otherwise: the anode for the current index is active and segments = encode(nibble[idx]), with dp = dp_reg[idx].
  - Outputs are registered one cycle after the counter/index state.
- Encoding: hex 0-F uses the standard table (a=bit0); b and d in lower case. Polarity is applied after encoding.
- Leading-zero blanking: when blank_lz=1, digit i>0 is blank (segments off, dp still honoured) if every nibble i..NUM_DIGITS-1 is 0. Digit 0 is never blanked.
- hold=1 with number_valid=1: no capture, and the strobe is not remembered after hold falls.
- Reset mid-slot: immediate return to the reset state; the scan restarts at digit 0 with a blank interval.

Optional Feature:
Macro SEVSEG_BCD_EN.
- Defined: number_in[BIN_W-1:0] is treated as unsigned binary. A capture loads a sequential double-dabble converter.
  - One shift per cycle, BIN_W cycles; busy=1 throughout.
  - disp_reg updates atomically on completion. busy falls in the cycle disp_reg updates.
  - number_valid while busy is stored in a 1-deep pending register (latest wins) and converted immediately after.
  - Value >= 10^NUM_DIGITS: every digit shows "-" (g only).
  - dp_in is captured at strobe time and applied on completion.
- Undefined: hex mode as above; busy tied 0; no converter logic.

Decomposition:
- Package sevseg_pkg: seg_t (logic [7:0]), the hex encode function, and constants SEG_DASH and SEG_OFF.
- Sub-module sevseg_bin2bcd holds the converter FSM (IDLE/SHIFT/DONE). It is compiled only under SEVSEG_BCD_EN.

Test Plan:
All cases use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
1. Reset: rst_n=0 -> sevenseg_out=8'hFF, sevseg_active=4'hF; both hold until the first non-blank slot after release.
2. Scan: number_in=16'h1A2F with a valid pulse.
   - Digit-0 slot gives sevseg_active=4'b1110, sevenseg_out=8'h8E.
   - Digit-1 slot gives 4'b1101, 8'hA4.
   - The index wraps 3->0 every 16 cycles.
   - Counter=0 gives 4'hF.
3. Blanking: number_in=16'h0005, blank_lz=1 -> digits 1-3 give sevenseg_out=8'hFF; digit 0 gives 8'h92. Drop blank_lz -> digits 1-3 give 8'hC0.
4. Hold: capture 16'h1234, then hold=1 with a valid strobe for 16'hFFFF -> display stays 1234. Release hold with no strobe -> still 1234.
5. BCD (SEVSEG_BCD_EN, BIN_W=16):
   - 16'd1234 -> busy high for 16 cycles, then the digits read 1,2,3,4.
   - 16'd12345 -> all digits 8'hBF.
   - A second strobe while busy converts after the first completes.
6. Reset mid-slot: assert rst_n=0 during the digit-2 slot -> outputs go inactive asynchronously; after release the scan starts at digit 0.
